// File: rtl/cdc_hs_src.sv
// Source side of a req/ack clock-domain handshake fed by a small FIFO; MODE 0 = 2-phase toggle, MODE 1 = 4-phase level.
// Latency: a word written into an empty FIFO with an idle link is launched on the following clk_i edge.
// Backpressure: s_ready drops while the FIFO is full; define CDC_HS_TIMEOUT_EN to enable the sticky ack-timeout flag.
module cdc_hs_src #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_valid,
    input  logic [DATA_W-1:0]      s_data,
    output logic                   s_ready,
    output logic                   req_o,
    output logic [DATA_W-1:0]      data_o,
    input  logic                   ack_i,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] count_o,
    input  logic                   err_clr,
    output logic                   err_timeout_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count_q;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   wr_en, launch, req_d, fifo_empty, link_idle;

    // Full is judged on registered occupancy, so a same-cycle pop never frees a slot early.
    assign s_ready    = (count_q != FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign wr_en      = s_valid && s_ready;
    assign count_o    = count_q;

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (launch)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, launch})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            ack_sync <= '0;
        else
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
    end
    assign ack_s = ack_sync[SYNC_STAGES-1];

    assign link_idle = (MODE == 0) ? (ack_s == req_o) : !ack_s;

    always_comb begin
        state_d = state_q;
        req_d   = req_o;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && link_idle) begin
                    launch  = 1'b1;
                    req_d   = (MODE == 0) ? !req_o : 1'b1;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (MODE == 0) begin
                    if (ack_s == req_o)
                        state_d = IDLE;
                end else if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!ack_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            req_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            state_q <= state_d;
            req_o   <= req_d;
            if (launch)
                data_o <= mem[rd_ptr];
        end
    end

    assign busy_o = (state_q != IDLE);

`ifdef CDC_HS_TIMEOUT_EN
    localparam logic [7:0] TMO      = 8'(TIMEOUT);
    localparam logic [7:0] TMO_LAST = TMO - 8'd1;

    logic [7:0] tmo_cnt;
    logic       in_wait, enter_wait, tmo_hit, err_q;

    assign in_wait    = (state_q != IDLE);
    assign enter_wait = (state_d != state_q) && (state_d != IDLE);
    assign tmo_hit    = in_wait && !enter_wait && (tmo_cnt == TMO_LAST);

    // Counter saturates at TIMEOUT so a cleared flag is not re-raised during the same wait.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (enter_wait)
                tmo_cnt <= '0;
            else if (in_wait && (tmo_cnt != TMO))
                tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo_hit)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;
        end
    end
    assign err_timeout_o = err_q;
`else
    logic unused_in;
    assign unused_in     = err_clr & (TIMEOUT >= 0);
    assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_src.sv
// Bench for cdc_hs_src: u0 runs MODE 0 (TIMEOUT 10), u1 runs MODE 1; directed tables/sequences then a randomized scoreboard run.
module tb_cdc_hs_src;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;
    localparam int NV    = 33;
`ifdef CDC_HS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sv[2], rdy[2], req[2], ack[2], busy[2], ec[2], err[2];
    logic [7:0] sd[2], dat[2];
    logic [2:0] cnt[2];

    always #5 clk = ~clk;

    cdc_hs_src #(.DATA_W(8), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .MODE(0), .TIMEOUT(10)) u0 (
        .clk_i(clk), .rst_i(rst_n), .s_valid(sv[0]), .s_data(sd[0]), .s_ready(rdy[0]),
        .req_o(req[0]), .data_o(dat[0]), .ack_i(ack[0]), .busy_o(busy[0]), .count_o(cnt[0]),
        .err_clr(ec[0]), .err_timeout_o(err[0]));

    cdc_hs_src #(.DATA_W(8), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .MODE(1), .TIMEOUT(255)) u1 (
        .clk_i(clk), .rst_i(rst_n), .s_valid(sv[1]), .s_data(sd[1]), .s_ready(rdy[1]),
        .req_o(req[1]), .data_o(dat[1]), .ack_i(ack[1]), .busy_o(busy[1]), .count_o(cnt[1]),
        .err_clr(ec[1]), .err_timeout_o(err[1]));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       ack;
        logic       req;
        logic [7:0] dat;
        logic       busy;
        logic [2:0] cnt;
        logic       rdy;
    } vec_t;
    vec_t tbl[NV];

    // Reference model state for the random run
    logic [7:0] mq[2][4096];
    int         mh[2], mt[2], dly[2];
    bit         pend[2];
    logic       tgt[2], preq[2], sv_in[2], rdy_in[2];
    logic [7:0] pdat[2], sd_in[2];
    logic       ah[2][SYNC+1];

    function automatic vec_t mk(logic a_sv, logic [7:0] a_sd, logic a_ack, logic e_req,
                                logic [7:0] e_dat, logic e_busy, logic [2:0] e_cnt, logic e_rdy);
        vec_t v;
        v.sv = a_sv; v.sd = a_sd; v.ack = a_ack; v.req = e_req;
        v.dat = e_dat; v.busy = e_busy; v.cnt = e_cnt; v.rdy = e_rdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst(input int d);
        chk($sformatf("rst%0d_req", d), req[d], 1'b0);
        chk($sformatf("rst%0d_data", d), dat[d], 8'h00);
        chk($sformatf("rst%0d_busy", d), busy[d], 1'b0);
        chk($sformatf("rst%0d_count", d), cnt[d], 3'd0);
        chk($sformatf("rst%0d_ready", d), rdy[d], 1'b1);
        chk($sformatf("rst%0d_err", d), err[d], 1'b0);
    endtask

    task automatic rand_cycle(input bit wr);
        for (int d = 0; d < 2; d++) begin
            bit   need;
            logic want;
            bit   launched;
            need = 1'b0;
            want = 1'b0;
            sv[d] = wr && ($urandom_range(0, 99) < 60);
            sd[d] = 8'($urandom);
            // Destination responder: echo req (toggle) or follow the 4-phase level protocol
            if (d == 0) begin
                need = (req[d] != ack[d]);
                want = req[d];
            end else if (req[d] && !ack[d]) begin
                need = 1'b1; want = 1'b1;
            end else if (!req[d] && ack[d]) begin
                need = 1'b1; want = 1'b0;
            end
            if (!pend[d] && need) begin
                pend[d] = 1'b1;
                dly[d]  = $urandom_range(0, 4);
                tgt[d]  = want;
            end
            if (pend[d]) begin
                if (dly[d] == 0) begin
                    ack[d]  = tgt[d];
                    pend[d] = 1'b0;
                end else begin
                    dly[d]--;
                end
            end
            sv_in[d] = sv[d]; sd_in[d] = sd[d]; rdy_in[d] = rdy[d];
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            bit launched;
            for (int k = SYNC; k > 0; k--) ah[d][k] = ah[d][k-1];
            ah[d][0] = ack[d];
            launched = (d == 0) ? (req[d] != preq[d]) : (req[d] && !preq[d]);
            if (launched) begin
                // Ack seen SYNC edges ago must show an idle link
                chk($sformatf("u%0d_launch_link_idle", d), ah[d][SYNC], (d == 0) ? preq[d] : 1'b0);
                chk($sformatf("u%0d_launch_nonempty", d), (mt[d] - mh[d]) > 0, 1'b1);
                if (mt[d] > mh[d]) begin
                    chk($sformatf("u%0d_launch_data", d), dat[d], mq[d][mh[d]]);
                    mh[d]++;
                end
            end else begin
                chk($sformatf("u%0d_data_hold", d), dat[d], pdat[d]);
            end
            if (sv_in[d] && rdy_in[d] && mt[d] < 4096) begin
                mq[d][mt[d]] = sd_in[d];
                mt[d]++;
            end
            chk($sformatf("u%0d_count", d), cnt[d], mt[d] - mh[d]);
            chk($sformatf("u%0d_ready", d), rdy[d], (mt[d] - mh[d]) < DEPTH);
            preq[d] = req[d];
            pdat[d] = dat[d];
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1, 8'hA5, 0, 0, 8'h00, 0, 1, 1);
        tbl[1]  = mk(0, 8'h00, 0, 1, 8'hA5, 1, 0, 1);
        tbl[2]  = mk(0, 8'h00, 0, 1, 8'hA5, 1, 0, 1);
        tbl[3]  = mk(0, 8'h00, 1, 1, 8'hA5, 1, 0, 1);
        tbl[4]  = mk(0, 8'h00, 1, 1, 8'hA5, 1, 0, 1);
        tbl[5]  = mk(0, 8'h00, 1, 1, 8'hA5, 0, 0, 1);
        tbl[6]  = mk(1, 8'h01, 1, 1, 8'hA5, 0, 1, 1);
        tbl[7]  = mk(1, 8'h02, 1, 0, 8'h01, 1, 1, 1);
        tbl[8]  = mk(1, 8'h03, 1, 0, 8'h01, 1, 2, 1);
        tbl[9]  = mk(1, 8'h04, 1, 0, 8'h01, 1, 3, 1);
        tbl[10] = mk(1, 8'h05, 1, 0, 8'h01, 1, 4, 0);
        tbl[11] = mk(1, 8'h06, 1, 0, 8'h01, 1, 4, 0);
        tbl[12] = mk(0, 8'h00, 1, 0, 8'h01, 1, 4, 0);
        tbl[13] = mk(0, 8'h00, 0, 0, 8'h01, 1, 4, 0);
        tbl[14] = mk(0, 8'h00, 0, 0, 8'h01, 1, 4, 0);
        tbl[15] = mk(0, 8'h00, 0, 0, 8'h01, 0, 4, 0);
        tbl[16] = mk(0, 8'h00, 0, 1, 8'h02, 1, 3, 1);
        tbl[17] = mk(0, 8'h00, 1, 1, 8'h02, 1, 3, 1);
        tbl[18] = mk(0, 8'h00, 1, 1, 8'h02, 1, 3, 1);
        tbl[19] = mk(0, 8'h00, 1, 1, 8'h02, 0, 3, 1);
        tbl[20] = mk(0, 8'h00, 1, 0, 8'h03, 1, 2, 1);
        tbl[21] = mk(0, 8'h00, 0, 0, 8'h03, 1, 2, 1);
        tbl[22] = mk(0, 8'h00, 0, 0, 8'h03, 1, 2, 1);
        tbl[23] = mk(0, 8'h00, 0, 0, 8'h03, 0, 2, 1);
        tbl[24] = mk(0, 8'h00, 0, 1, 8'h04, 1, 1, 1);
        tbl[25] = mk(0, 8'h00, 1, 1, 8'h04, 1, 1, 1);
        tbl[26] = mk(0, 8'h00, 1, 1, 8'h04, 1, 1, 1);
        tbl[27] = mk(0, 8'h00, 1, 1, 8'h04, 0, 1, 1);
        tbl[28] = mk(0, 8'h00, 1, 0, 8'h05, 1, 0, 1);
        tbl[29] = mk(0, 8'h00, 0, 0, 8'h05, 1, 0, 1);
        tbl[30] = mk(0, 8'h00, 0, 0, 8'h05, 1, 0, 1);
        tbl[31] = mk(0, 8'h00, 0, 0, 8'h05, 0, 0, 1);
        tbl[32] = mk(0, 8'h00, 0, 0, 8'h05, 0, 0, 1);

        for (int d = 0; d < 2; d++) begin
            sv[d] = 1'b0; sd[d] = 8'h00; ack[d] = 1'b0; ec[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_rst(0);
        chk_rst(1);
        rst_n = 1'b1;

        // MODE 0 basic transfer, FIFO fill to full, ordered delivery
        for (int i = 0; i < NV; i++) begin
            sv[0] = tbl[i].sv; sd[0] = tbl[i].sd; ack[0] = tbl[i].ack;
            tick();
            chk($sformatf("tbl%0d_req", i), req[0], tbl[i].req);
            chk($sformatf("tbl%0d_data", i), dat[0], tbl[i].dat);
            chk($sformatf("tbl%0d_busy", i), busy[0], tbl[i].busy);
            chk($sformatf("tbl%0d_count", i), cnt[0], tbl[i].cnt);
            chk($sformatf("tbl%0d_ready", i), rdy[0], tbl[i].rdy);
            chk($sformatf("tbl%0d_err", i), err[0], 1'b0);
        end
        sv[0] = 1'b0;

        // MODE 1 four-phase transfer, no relaunch before ack low is synchronised
        sv[1] = 1'b1; sd[1] = 8'h3C;
        tick();
        sv[1] = 1'b0;
        chk("m1_wr_count", cnt[1], 3'd1);
        tick();
        chk("m1_launch_req", req[1], 1'b1);
        chk("m1_launch_data", dat[1], 8'h3C);
        chk("m1_launch_busy", busy[1], 1'b1);
        repeat (2) tick();
        chk("m1_wait_req", req[1], 1'b1);
        ack[1] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("m1_ackhi%0d_req", k), req[1], k < 3);
            chk($sformatf("m1_ackhi%0d_busy", k), busy[1], 1'b1);
        end
        ack[1] = 1'b0; sv[1] = 1'b1; sd[1] = 8'h5A;
        for (int k = 1; k <= 4; k++) begin
            tick();
            sv[1] = 1'b0;
            chk($sformatf("m1_acklo%0d_req", k), req[1], k == 4);
            chk($sformatf("m1_acklo%0d_data", k), dat[1], (k == 4) ? 8'h5A : 8'h3C);
            chk($sformatf("m1_acklo%0d_busy", k), busy[1], k != 3);
            chk($sformatf("m1_acklo%0d_count", k), cnt[1], (k == 4) ? 3'd0 : 3'd1);
        end
        ack[1] = 1'b1;
        repeat (3) tick();
        chk("m1_second_req_fall", req[1], 1'b0);
        ack[1] = 1'b0;
        repeat (3) tick();
        chk("m1_second_idle", busy[1], 1'b0);

        // Reset in WAIT_HI with three words queued
        sv[0] = 1'b1; sd[0] = 8'h11; tick();
        sd[0] = 8'h22; tick();
        sd[0] = 8'h33; tick();
        sd[0] = 8'h44; tick();
        sv[0] = 1'b0;
        chk("midrst_pre_count", cnt[0], 3'd3);
        chk("midrst_pre_busy", busy[0], 1'b1);
        chk("midrst_pre_data", dat[0], 8'h11);
        #2 rst_n = 1'b0;
        #1;
        chk_rst(0);
        chk_rst(1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) tick();
        chk("midrst_post_req", req[0], 1'b0);
        chk("midrst_post_busy", busy[0], 1'b0);
        chk("midrst_post_count", cnt[0], 3'd0);

        // Reset released with a stale ack high
        ack[0] = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();
        sv[0] = 1'b1; sd[0] = 8'h77;
        tick();
        sv[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("stale%0d_req", k), req[0], 1'b0);
            chk($sformatf("stale%0d_busy", k), busy[0], 1'b0);
        end
        chk("stale_count", cnt[0], 3'd1);
        ack[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("stale_rel%0d_req", k), req[0], k == 3);
        end
        chk("stale_rel_data", dat[0], 8'h77);
        chk("stale_rel_count", cnt[0], 3'd0);
        ack[0] = 1'b1;
        repeat (3) tick();
        chk("stale_done_busy", busy[0], 1'b0);

        // Ack timeout (flag only exists when the feature is built in)
        sv[0] = 1'b1; sd[0] = 8'h99;
        tick();
        sv[0] = 1'b0;
        tick();
        chk("tmo_launch_req", req[0], 1'b0);
        chk("tmo_launch_data", dat[0], 8'h99);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("tmo_cyc%0d_err", k), err[0], TMO_EN && (k >= 10));
        end
        chk("tmo_still_waiting", busy[0], 1'b1);
        ec[0] = 1'b1;
        tick();
        ec[0] = 1'b0;
        chk("tmo_clr_err", err[0], 1'b0);
        repeat (3) tick();
        chk("tmo_clr_stays", err[0], 1'b0);
        ack[0] = 1'b0;
        repeat (3) tick();
        chk("tmo_done_busy", busy[0], 1'b0);
        chk("tmo_done_data", dat[0], 8'h99);

        // Randomized traffic against the scoreboard
        for (int d = 0; d < 2; d++) begin
            mh[d] = 0; mt[d] = 0; pend[d] = 1'b0; dly[d] = 0; tgt[d] = 1'b0;
            preq[d] = req[d]; pdat[d] = dat[d];
            for (int k = 0; k <= SYNC; k++) ah[d][k] = ack[d];
        end
        repeat (2000) rand_cycle(1'b1);
        for (int i = 0; i < 400; i++) begin
            if (mh[0] == mt[0] && mh[1] == mt[1] && !busy[0] && !busy[1])
                break;
            rand_cycle(1'b0);
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("drain%0d_undelivered", d), mt[d] - mh[d], 0);
            chk($sformatf("drain%0d_busy", d), busy[d], 1'b0);
            chk($sformatf("drain%0d_count", d), cnt[d], 3'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cdc_hs_src.md
CDC_HS_SRC -- requirements
Module: cdc_hs_src

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning source FIFO entries; power of two, at least 2.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning ack synchroniser flops; at least 2.
REQ-004 The block SHALL have parameter MODE, default 0, meaning handshake protocol: 0 = 2-phase toggle, 1 = 4-phase level.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, meaning ack wait limit in clk_i cycles, 8-bit counter.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port s_valid, input, 1 bit: the producer offers s_data.
REQ-009 The block SHALL have port s_data, input, DATA_W bits: the producer payload.
REQ-010 The block SHALL have port s_ready, output, 1 bit: the FIFO accepts a word.
REQ-011 The block SHALL have port req_o, output, 1 bit: registered request to the destination domain.
REQ-012 The block SHALL have port data_o, output, DATA_W bits: registered payload, stable while a transfer is outstanding.
REQ-013 The block SHALL have port ack_i, input, 1 bit: asynchronous acknowledge from the destination domain.
REQ-014 The block SHALL have port busy_o, output, 1 bit: high when the FSM is not in IDLE.
REQ-015 The block SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-016 The block SHALL have port err_clr, input, 1 bit: clears err_timeout_o.
REQ-017 The block SHALL have port err_timeout_o, output, 1 bit: sticky ack-timeout flag.

Function
REQ-018 s_ready SHALL equal NOT full, taken from registered occupancy only; a write on a full FIFO is ignored even when a pop occurs in the same cycle.
REQ-019 A write SHALL occur on an edge where s_valid and s_ready are both high; a write and a pop on the same edge SHALL leave count_o unchanged.
REQ-020 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-021 ack_i SHALL pass through SYNC_STAGES flops to give ack_s; no other logic SHALL sample ack_i.
REQ-022 The FSM SHALL have states IDLE, WAIT_HI and WAIT_LO; WAIT_LO SHALL be used only when MODE=1.
REQ-023 Launch condition: state is IDLE, the FIFO is non-empty, and the link is idle. The link is idle when ack_s equals req_o (MODE 0) or when ack_s is 0 (MODE 1).
REQ-024 On launch, on one edge: data_o SHALL load the FIFO head, the FIFO SHALL pop, req_o SHALL toggle (MODE 0) or be set to 1 (MODE 1), and the FSM SHALL enter WAIT_HI.
REQ-025 A word written at edge N into an empty FIFO with an idle link SHALL appear on data_o/req_o after edge N+1.
REQ-026 MODE 0: in WAIT_HI, when ack_s equals req_o, the FSM SHALL go to IDLE; the next launch is permitted on the following edge.
REQ-027 MODE 1: in WAIT_HI, when ack_s is 1, req_o SHALL be cleared and the FSM SHALL go to WAIT_LO; in WAIT_LO, when ack_s is 0, the FSM SHALL go to IDLE.
REQ-028 data_o SHALL change only on a launch edge.
REQ-029 busy_o SHALL be high when state is not IDLE.
REQ-030 An ack_s transition while in IDLE SHALL not change state or outputs; it only affects the link-idle condition.

Reset
REQ-031 While rst_i is low: req_o=0, data_o=0, count_o=0, FIFO pointers=0, synchroniser flops=0, state=IDLE, err_timeout_o=0, timeout counter=0, s_ready=1, busy_o=0.
REQ-032 Reset mid-transfer SHALL abandon the outstanding word and all queued words.
REQ-033 After reset, a stale ack_s=1 SHALL block launches until the link is idle (REQ-023).

Configuration
REQ-034 With CDC_HS_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to WAIT_HI/WAIT_LO and increment each cycle in those states.
REQ-035 With CDC_HS_TIMEOUT_EN defined: when the counter reaches TIMEOUT, err_timeout_o SHALL set and the counter SHALL saturate; the FSM SHALL keep waiting.
REQ-036 With CDC_HS_TIMEOUT_EN defined: err_clr SHALL clear err_timeout_o, with a set in the same cycle taking priority.
REQ-037 Without CDC_HS_TIMEOUT_EN: the counter SHALL be absent, err_timeout_o SHALL be tied to 0, and err_clr SHALL be ignored.

Verification
REQ-038 MODE 0, idle link, write 0xA5 at edge 0 -> data_o=0xA5 and req_o 0->1 after edge 1; ack_i raised -> busy_o low SYNC_STAGES+1 edges later.
REQ-039 MODE 1, word 0x3C -> req_o rises, then falls SYNC_STAGES+1 edges after ack_i=1; IDLE SYNC_STAGES+1 edges after ack_i=0; no relaunch before that.
REQ-040 DEPTH=4, hold ack_i constant, write 0x01..0x06 -> launch 0x01, FIFO holds 0x02..0x05 with s_ready=0 and count_o=4, 0x06 not accepted; acks then deliver 0x02..0x05 in order.
REQ-041 Release rst_i with ack_i=1, MODE 0, FIFO loaded -> no launch until ack_i=0 is synchronised.
REQ-042 Assert rst_i low in WAIT_HI with 3 words queued -> all outputs at reset values immediately; no further launches until new writes occur.
REQ-043 CDC_HS_TIMEOUT_EN defined, TIMEOUT=10, ack_i withheld -> err_timeout_o=1 at cycle 10 after launch; err_clr pulse -> 0; transfer completes when ack arrives.
